// File: rtl/div_scheduler.sv
// div_scheduler: two-port round-robin front end for one external 8-bit
// restoring divider. Grants a requesting port, latches its operands, runs
// the divider (held in reset except while BUSY), captures the result and
// pulses the granted port's ack for one cycle.
// Optional feature macro: DIV_ZERO_BYPASS_EN -- when defined, a granted
// request with divisor 0 skips the divider and answers next cycle with
// quo=8'hFF, rem=a, err=1. When undefined, err is tied to 0.
module div_scheduler (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic [7:0] a0,
    input  logic [7:0] b0,
    input  logic [7:0] a1,
    input  logic [7:0] b1,
    output logic       ack0,
    output logic       ack1,
    output logic [7:0] quo,
    output logic [7:0] rem,
    output logic       err,
    output logic       busy,
    output logic [7:0] div_a,
    output logic [7:0] div_b,
    output logic       div_rst,
    input  logic       div_done,
    input  logic [7:0] div_quo,
    input  logic [7:0] div_rem
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t     state;
    state_t     state_next;
    logic       port;
    logic       last_port;
    logic       grant_valid;
    logic       grant_port;
    logic [7:0] sel_a;
    logic [7:0] sel_b;
    logic       bypass;

    // Arbitration: a lone request wins outright, a tie goes to the port not served last
    always_comb begin
        grant_valid = req0 | req1;
        grant_port  = 1'b0;
        if (req0 && req1) begin
            grant_port = ~last_port;
        end else if (req1) begin
            grant_port = 1'b1;
        end
        sel_a = grant_port ? a1 : a0;
        sel_b = grant_port ? b1 : b0;
    end

`ifdef DIV_ZERO_BYPASS_EN
    assign bypass = grant_valid && (sel_b == 8'd0);

    // Divide-by-zero flag is decided at grant time and held through the response
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (state == IDLE && grant_valid) begin
            err <= (sel_b == 8'd0);
        end
    end
`else
    assign bypass = 1'b0;
    assign err    = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and state-decoded outputs
    always_comb begin
        state_next = state;
        ack0       = 1'b0;
        ack1       = 1'b0;
        busy       = (state != IDLE);
        div_rst    = (state != BUSY);
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    state_next = bypass ? RESP : START;
                end
            end
            START: begin
                state_next = BUSY;
            end
            BUSY: begin
                if (div_done) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                ack0       = (port == 1'b0);
                ack1       = (port == 1'b1);
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: operand latch at grant, result capture and pointer update on entry to RESP
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            port      <= 1'b0;
            last_port <= 1'b1;
            div_a     <= 8'd0;
            div_b     <= 8'd0;
            quo       <= 8'd0;
            rem       <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        port  <= grant_port;
                        div_a <= sel_a;
                        div_b <= sel_b;
                        if (bypass) begin
                            quo       <= 8'hFF;
                            rem       <= sel_a;
                            last_port <= grant_port;
                        end
                    end
                end
                BUSY: begin
                    if (div_done) begin
                        quo       <= div_quo;
                        rem       <= div_rem;
                        last_port <= port;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_scheduler.sv
// tb_div_scheduler: directed bench for div_scheduler with a behavioural
// model of the external divider and a scoreboard of expected responses.
module tb_div_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, req1;
    logic [7:0] a0, b0, a1, b1;
    logic       ack0, ack1;
    logic [7:0] quo, rem;
    logic       err, busy;
    logic [7:0] div_a, div_b;
    logic       div_rst;
    logic       div_done;
    logic [7:0] div_quo, div_rem;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic       port;
        logic [7:0] quo;
        logic [7:0] rem;
        logic       err;
    } exp_t;

    exp_t sb[$];

    div_scheduler dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req0     (req0),
        .req1     (req1),
        .a0       (a0),
        .b0       (b0),
        .a1       (a1),
        .b1       (b1),
        .ack0     (ack0),
        .ack1     (ack1),
        .quo      (quo),
        .rem      (rem),
        .err      (err),
        .busy     (busy),
        .div_a    (div_a),
        .div_b    (div_b),
        .div_rst  (div_rst),
        .div_done (div_done),
        .div_quo  (div_quo),
        .div_rem  (div_rem)
    );

    always #5 clk = ~clk;

    // Divider model: done rises after nine edges out of reset, result held until reset
    logic [3:0] dcnt;
    always @(posedge clk) begin
        if (div_rst) begin
            dcnt <= 4'd0;
        end else if (dcnt != 4'd9) begin
            dcnt <= dcnt + 4'd1;
        end
    end
    assign div_done = (dcnt == 4'd9);
    assign div_quo  = (div_b == 8'd0) ? 8'hFF : div_a / div_b;
    assign div_rem  = (div_b == 8'd0) ? div_a : div_a % div_b;

`ifdef DIV_ZERO_BYPASS_EN
    localparam logic ZERO_ERR = 1'b1;
    localparam int   ZERO_LAT = 1;
`else
    localparam logic ZERO_ERR = 1'b0;
    localparam int   ZERO_LAT = 12;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic apply_stimulus(input logic port, input logic [7:0] a, input logic [7:0] b,
                                  input logic [7:0] eq, input logic [7:0] er, input logic ee);
        exp_t e;
        e.port = port;
        e.quo  = eq;
        e.rem  = er;
        e.err  = ee;
        sb.push_back(e);
        if (port) begin
            a1 = a; b1 = b; req1 = 1'b1;
        end else begin
            a0 = a; b0 = b; req0 = 1'b1;
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Compare an observed ack against the oldest scoreboard entry
    task automatic check_output(input int lat, input int exp_lat);
        exp_t e;
        total++;
        assert (sb.size() != 0) else begin
            bad++;
            $error("[TB] FAIL sb_empty observed=ack expected=none");
            return;
        end
        e = sb.pop_front();
        check("ack_port", {31'd0, ack1}, {31'd0, e.port});
        check("quo", {24'd0, quo}, {24'd0, e.quo});
        check("rem", {24'd0, rem}, {24'd0, e.rem});
        check("err", {31'd0, err}, {31'd0, e.err});
        if (exp_lat > 0) begin
            check("latency", lat, exp_lat);
        end
    endtask

    // Wait (bounded) for an ack, score it, optionally drop the served req
    task automatic wait_ack(input int exp_lat, input bit drop);
        int  k;
        bit  seen;
        k    = 0;
        seen = 1'b0;
        while (!seen && k < 40) begin
            @(negedge clk);
            k++;
            if (ack0 && ack1) begin
                check("ack_overlap", 32'd1, 32'd0);
            end
            if (ack0 || ack1) begin
                seen = 1'b1;
            end
        end
        if (!seen) begin
            check("ack_timeout", 32'd0, 32'd1);
        end else begin
            check_output(k, exp_lat);
            if (drop) begin
                if (ack0) req0 = 1'b0;
                if (ack1) req1 = 1'b0;
            end
        end
    endtask

    initial begin
        req0 = 1'b0; req1 = 1'b0;
        a0 = 8'd0; b0 = 8'd0; a1 = 8'd0; b1 = 8'd0;
        apply_reset();

        // Reset state
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ack", {30'd0, ack1, ack0}, 32'd0);
        check("rst_quo", {24'd0, quo}, 32'd0);
        check("rst_rem", {24'd0, rem}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_div_ab", {16'd0, div_a, div_b}, 32'd0);
        check("rst_div_rst", {31'd0, div_rst}, 32'd1);

        // Single request, fixed latency, busy drops afterwards
        apply_stimulus(1'b0, 8'd100, 8'd7, 8'd14, 8'd2, 1'b0);
        wait_ack(12, 1'b1);
        @(negedge clk);
        check("busy_after", {31'd0, busy}, 32'd0);

        // Lone request wins even though the pointer now favours port 1
        apply_stimulus(1'b0, 8'd37, 8'd5, 8'd7, 8'd2, 1'b0);
        wait_ack(12, 1'b1);
        @(negedge clk);

        // Simultaneous requests right after reset: port 0 first
        apply_reset();
        apply_stimulus(1'b0, 8'd200, 8'd10, 8'd20, 8'd0, 1'b0);
        apply_stimulus(1'b1, 8'd9, 8'd4, 8'd2, 8'd1, 1'b0);
        wait_ack(12, 1'b1);
        wait_ack(-1, 1'b1);
        @(negedge clk);

        // Both held for four transactions: strict alternation
        apply_stimulus(1'b0, 8'd81, 8'd9, 8'd9, 8'd0, 1'b0);
        apply_stimulus(1'b1, 8'd17, 8'd3, 8'd5, 8'd2, 1'b0);
        sb.push_back(sb[0]);
        sb.push_back(sb[1]);
        wait_ack(12, 1'b0);
        wait_ack(-1, 1'b0);
        wait_ack(-1, 1'b0);
        wait_ack(-1, 1'b1);
        req0 = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Divide by zero
        apply_stimulus(1'b1, 8'd55, 8'd0, 8'hFF, 8'd55, ZERO_ERR);
        wait_ack(ZERO_LAT, 1'b1);
        @(negedge clk);

        // Operand change during BUSY is ignored
        apply_stimulus(1'b0, 8'd100, 8'd7, 8'd14, 8'd2, 1'b0);
        repeat (3) @(negedge clk);
        a0 = 8'd50;
        wait_ack(9, 1'b1);
        @(negedge clk);

        // Reset mid-BUSY aborts, held req is served afresh
        apply_stimulus(1'b0, 8'd100, 8'd7, 8'd14, 8'd2, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("abort_noack", {30'd0, ack1, ack0}, 32'd0);
        end
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_ack", {30'd0, ack1, ack0}, 32'd0);
        check("abort_qr", {16'd0, quo, rem}, {16'd0, 8'd0, 8'd0});
        check("abort_div_a", {24'd0, div_a}, 32'd0);
        check("abort_div_rst", {31'd0, div_rst}, 32'd1);
        rst_n = 1'b1;
        wait_ack(12, 1'b1);
        @(negedge clk);

        check("sb_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/div_scheduler.md
DIV_SCHEDULER -- requirements
Module: div_scheduler

Interface
REQ-001 SHALL have ports: clk input 1, single clock; all logic on its rising edge.
REQ-002 SHALL have ports: rst_n input 1, synchronous active-low reset.
REQ-003 SHALL have ports: req0/req1 input 1 each, request from port 0/1; held high until the matching ack.
REQ-004 SHALL have ports: a0/a1 input 8 each, dividend of port 0/1; b0/b1 input 8 each, divisor of port 0/1.
REQ-005 SHALL have ports: ack0/ack1 output 1 each, one-cycle completion pulse to port 0/1.
REQ-006 SHALL have ports: quo output 8, quotient; rem output 8, remainder; err output 1, divide-by-zero flag. All three are valid only while ack0 or ack1 is high.
REQ-007 SHALL have ports: busy output 1, high in every state except IDLE.
REQ-008 SHALL have ports: div_a output 8, div_b output 8, div_rst output 1 (active-high), div_done input 1, div_quo input 8, div_rem input 8. These connect to one external 8-bit restoring divider.

Function
REQ-009 SHALL implement FSM states IDLE, START, BUSY and RESP, all registered.
REQ-010 SHALL, in IDLE with at least one req high, grant one port, latch its a/b into div_a/div_b, record the granted port id, and go to START.
REQ-011 SHALL arbitrate round-robin when both reqs are high: grant the port not served most recently. The pointer favours port 0 after reset.
REQ-012 SHALL, with exactly one req high, grant that port regardless of the pointer.
REQ-013 SHALL drive div_rst=1 in IDLE, START and RESP, and div_rst=0 only in BUSY.
REQ-014 SHALL leave START for BUSY after exactly one cycle.
REQ-015 SHALL stay in BUSY until div_done is sampled high, then capture div_quo/div_rem into quo/rem and go to RESP.
REQ-016 SHALL assert the granted port's ack for exactly the RESP cycle, then return to IDLE.
REQ-017 SHALL, for a divider-served request, assert ack in the cycle after the 11th rising edge following the edge that sampled req.
REQ-018 SHALL treat a req still high in the cycle after its ack as a new request.
REQ-019 SHALL ignore req changes and a/b changes while not in IDLE; operands are latched only at grant.
REQ-020 SHALL update the round-robin pointer to the served port on entry to RESP.
REQ-021 SHALL never assert ack0 and ack1 in the same cycle.
REQ-022 SHALL not sample div_done in IDLE, START or RESP.

Reset
REQ-023 SHALL, while rst_n=0 at a rising edge, enter IDLE and clear quo, rem, err, ack0, ack1, busy, div_a and div_b to 0, with div_rst=1 and the pointer favouring port 0.
REQ-024 SHALL, on reset during START, BUSY or RESP, abort the operation with no ack issued. The aborted request is re-arbitrated from IDLE if its req is still high.

Configuration
REQ-025 SHALL, with macro DIV_ZERO_BYPASS_EN defined, handle a granted request with b=0 as follows: go IDLE->RESP directly, set quo=8'hFF, rem=a and err=1, and assert ack in the cycle after the sampling edge.
REQ-026 SHALL, without DIV_ZERO_BYPASS_EN, send b=0 requests through the divider like any other request, with err tied to 0.

Verification
REQ-027 SHALL pass: req0 with a0=100, b0=7 -> ack0 in the cycle after the 11th edge, quo=14, rem=2, err=0, busy low the next cycle.
REQ-028 SHALL pass: req0 (200/10) and req1 (9/4) raised in the same cycle after reset -> ack0 first with quo=20, rem=0; then ack1 with quo=2, rem=1; no overlap of acks.
REQ-029 SHALL pass: req0 and req1 held high continuously for 4 transactions -> acks alternate port 0, 1, 0, 1.
REQ-030 SHALL pass: req1 with a1=55, b1=0 -> with DIV_ZERO_BYPASS_EN, ack1 one cycle later with quo=8'hFF, rem=55, err=1; without it, ack1 after 11 edges with quo=8'hFF, rem=55, err=0.
REQ-031 SHALL pass: rst_n pulled low for 1 cycle mid-BUSY of a 100/7 request with req0 held -> no ack during the aborted operation, FSM in IDLE, outputs zero, then a fresh ack0 with quo=14, rem=2 after 11 further edges.
REQ-032 SHALL pass: a0 changed from 100 to 50 during BUSY -> result still quo=14, rem=2.
